multicycle_controller: RTL
==========================

# multicycle_controller

Parametrised control unit for the multicycle RV32I datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It waits on a memory ready handshake, resolves all six branch conditions from ALU flags, and flags illegal opcodes. It sits between the instruction register (`op`/`funct3`), the ALU flag outputs, the datapath muxes/enables and the unified instruction/data memory port.

## Interface
- `HAS_MEM_HANDSHAKE`, default 1: when 1, memory states hold until `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `TRAP_ON_ILLEGAL`, default 1: when 1, an unknown opcode enters TRAP; when 0, it returns to FETCH, so the instruction acts as a NOP.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `op` input 7: opcode from the instruction register.
- `funct3` input 3: from the instruction register.
- `Zero`, `less_than`, `unsigned_less_than` input 1 each: ALU flags for rs1 vs rs2.
- `mem_ready` input 1: memory completes the current `mem_req` in this cycle.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` output 1: store strobe.
- `IRWrite` output 1: loads the instruction register and OldPC.
- `RegWrite` output 1: register file write enable.
- `mem_req` output 1: memory access request.
- `ResultSrc` output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` output 2: 00 PC, 01 OldPC, 10 rs1 reg, 11 zero.
- `ALUSrcB` output 2: 00 rs2 reg, 01 ImmExt, 10 constant 4.
- `ALUOp` output 2: 00 add, 01 subtract/compare, 10 funct-decoded.
- `ImmSrc` output 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `illegal_instr` output 1: sticky illegal-opcode flag.
- `state_dbg` output 4: current state encoding, for debug only.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, UTYPE, TRAP.
- Every output is a function of the state (Moore). The only exceptions are `PCWrite` in BRANCH and FETCH, and `IRWrite` in FETCH. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite` and `PCWrite` are asserted only when `mem_ready` is high.
  - Moves to DECODE on `mem_ready`; otherwise stays in FETCH.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ImmSrc`=010; latches the branch target into ALUOut. Dispatch on `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UTYPE
  - any other opcode → TRAP, or FETCH if `TRAP_ON_ILLEGAL`=0
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=000 for loads and 001 for stores. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `mem_req`=1, `AdrSrc`=1; holds until `mem_ready`, then MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1; holds until `mem_ready`, then FETCH. `MemWrite` stays high for every wait cycle.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10, then ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=000, `ALUOp`=10, then ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1, then FETCH.
- BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00. `PCWrite` is the taken condition for `funct3`:
  - 000 `Zero`; 001 !`Zero`
  - 100 `less_than`; 101 !`less_than`
  - 110 `unsigned_less_than`; 111 !`unsigned_less_than`
  - 010 and 011 are never taken.
  - Always goes to FETCH next.
- JAL: `ResultSrc`=00, `PCWrite`=1, `ALUSrcA`=01, `ALUSrcB`=10, then ALUWB, which writes OldPC+4.
- JALR: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=000, `ResultSrc`=10, `PCWrite`=1, then LINK.
- LINK: `ALUSrcA`=01, `ALUSrcB`=10, then ALUWB.
- UTYPE: `ALUSrcA`=11 if `op`[5]=1 (lui), 01 otherwise (auipc); `ALUSrcB`=01, `ImmSrc`=100; then ALUWB.
- TRAP: all strobes 0, `illegal_instr`=1. Only `reset` leaves TRAP.

## Timing
- Reset:
  - `reset` sampled high → state is FETCH after that edge and `illegal_instr`=0.
  - While `reset`=1, every output is forced to 0, including `mem_req`. This also applies when reset lands mid-operation, e.g. mid-MEMWRITE: the store strobe drops in that cycle.
- Cycle counts with `mem_ready` held high: R/I-type 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui/auipc 4. Each wait cycle adds 1 to FETCH, MEMREAD or MEMWRITE.
- Handshake: `mem_req` is held continuously from state entry until the cycle in which `mem_ready`=1. A request is never withdrawn before that.
- `mem_ready` high outside a memory state is ignored.
- With `HAS_MEM_HANDSHAKE`=0, every memory state lasts exactly 1 cycle.

## Test plan
- lw with `mem_ready` low for 2 cycles in FETCH and 1 in MEMREAD → `mem_req` high for 3 FETCH cycles. `IRWrite`/`PCWrite` pulse exactly once. Instruction completes in 8 cycles with a single `RegWrite` pulse carrying `ResultSrc`=01.
- beq with `Zero`=1, then bne with `Zero`=1 → `PCWrite`=1 in BRANCH for the first and 0 for the second. Each instruction takes 3 cycles.
- bgeu with `unsigned_less_than`=0, then blt with `less_than`=0 → taken, then not taken. `funct3`=010 → not taken and no trap.
- jalr sequence → FETCH, DECODE, JALR, LINK, ALUWB. `PCWrite` is high in FETCH and JALR. `RegWrite` is high only in ALUWB, with `ResultSrc`=00.
- op=1111111 with `TRAP_ON_ILLEGAL`=1 → TRAP, `illegal_instr`=1 and held for 10 cycles, all strobes 0. Then `reset` → FETCH and flag cleared. Same op with `TRAP_ON_ILLEGAL`=0 → back to FETCH after DECODE, no `RegWrite` or `MemWrite`.
- sw with `mem_ready` low, `reset` asserted in the second MEMWRITE cycle → `MemWrite`=0 and `mem_req`=0 that cycle, FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, waits on the memory handshake, resolves branches.
module multicycle_controller #(
    parameter bit HAS_MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_ON_ILLEGAL   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       less_than,
    input  logic       unsigned_less_than,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       mem_req,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6,  EXECI   = 4'd7,
        ALUWB    = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR    = 4'd11,
        LINK     = 4'd12, UTYPE  = 4'd13, TRAP   = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       mem_req;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   mem_rdy_s;
    logic   taken_s;

    // Static per-state controls; op only matters for the load/store and lui/auipc splits.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 3'b010; end
            MEMADR:   begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.imm_src   = opc[5] ? 3'b001 : 3'b000;
            end
            MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXECI:    begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10;
            end
            ALUWB:    c.reg_write = 1'b1;
            BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
            JAL:      begin c.pc_write = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            JALR:     begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.result_src = 2'b10; c.pc_write = 1'b1;
            end
            LINK:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            UTYPE:    begin
                c.alu_src_a = opc[5] ? 2'b11 : 2'b01;
                c.alu_src_b = 2'b01; c.imm_src = 3'b100;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign mem_rdy_s = HAS_MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Branch condition from ALU flags.
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'b000:  taken_s = Zero;
            3'b001:  taken_s = ~Zero;
            3'b100:  taken_s = less_than;
            3'b101:  taken_s = ~less_than;
            3'b110:  taken_s = unsigned_less_than;
            3'b111:  taken_s = ~unsigned_less_than;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_rdy_s) state_d = DECODE; else state_d = FETCH;
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b1100111:             state_d = JALR;
                    7'b0110111, 7'b0010111: state_d = UTYPE;
                    default:                state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEMADR:   if (op[5]) state_d = MEMWRITE; else state_d = MEMREAD;
            MEMREAD:  if (mem_rdy_s) state_d = MEMWB; else state_d = MEMREAD;
            MEMWRITE: if (mem_rdy_s) state_d = FETCH; else state_d = MEMWRITE;
            EXECR, EXECI, JAL, LINK, UTYPE: state_d = ALUWB;
            JALR:     state_d = LINK;
            MEMWB, ALUWB, BRANCH: state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // State, registered Moore controls and the sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ctrl_q    <= decode_ctrl(FETCH, op);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, op);
            if (state_d == TRAP) illegal_q <= 1'b1;
            else                 illegal_q <= illegal_q;
        end
    end

    // Reset blanks every output in the same cycle, so an in-flight store strobe drops at once.
    always_comb begin
        if (reset) begin
            PCWrite = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
            RegWrite = 1'b0; mem_req = 1'b0; ResultSrc = 2'b00; ALUSrcA = 2'b00;
            ALUSrcB = 2'b00; ALUOp = 2'b00; ImmSrc = 3'b000;
            illegal_instr = 1'b0; state_dbg = 4'd0;
        end else begin
            PCWrite  = ctrl_q.pc_write
                     | ((state_q == FETCH) & mem_rdy_s)
                     | ((state_q == BRANCH) & taken_s);
            IRWrite  = (state_q == FETCH) & mem_rdy_s;
            AdrSrc   = ctrl_q.adr_src;
            MemWrite = ctrl_q.mem_write;
            RegWrite = ctrl_q.reg_write;
            mem_req  = ctrl_q.mem_req;
            ResultSrc = ctrl_q.result_src;
            ALUSrcA  = ctrl_q.alu_src_a;
            ALUSrcB  = ctrl_q.alu_src_b;
            ALUOp    = ctrl_q.alu_op;
            ImmSrc   = ctrl_q.imm_src;
            illegal_instr = illegal_q;
            state_dbg = state_q;
        end
    end

endmodule
